// File: rtl/prog_loader_pkg.sv
// Shared types and default sizes for the program loader.
package prog_loader_pkg;

  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/loader_chk_accum.sv
// Running checksum of written bytes (mod 2**DATA_W) with an equality compare.
// Only elaborated when PROG_LOADER_CHKSUM_EN is defined.
`ifdef PROG_LOADER_CHKSUM_EN
module loader_chk_accum
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_acc,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_match_c
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sum <= '0;
    end else if (i_acc) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_match_c = (r_sum == i_data);

endmodule
`endif

// File: rtl/prog_loader.sv
// Streams program bytes into instruction memory from address 0, holding the PC via o_inCmd.
// Optional checksum on the last byte when PROG_LOADER_CHKSUM_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_inCmd,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [ADDR_W:0]   o_len,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned       LEN_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              w_xfer;

  assign w_xfer = i_valid && o_ready;

`ifdef PROG_LOADER_CHKSUM_EN
  logic w_clr;
  logic w_acc;
  logic w_match;

  assign w_clr = i_start && (r_state != DONE);
  assign w_acc = w_xfer && !i_start && !i_last;

  loader_chk_accum #(.DATA_W(DATA_W)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_acc     (w_acc),
    .i_data    (i_data),
    .o_match_c (w_match)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      o_ready <= 1'b0;
      o_inCmd <= 1'b0;
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
      o_len   <= '0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_we   <= 1'b0;
      o_done <= 1'b0;
      case (r_state)
        IDLE, ERR: begin
          if (i_start) begin
            r_state <= LOAD;
            r_addr  <= '0;
            o_len   <= '0;
            o_err   <= 1'b0;
            o_ready <= 1'b1;
            o_inCmd <= 1'b1;
          end
        end
        LOAD: begin
          // restart wins over a same-cycle transfer
          if (i_start) begin
            r_addr <= '0;
            o_len  <= '0;
          end else if (w_xfer) begin
            if (i_last) begin
              o_ready <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
              if (w_match) begin
                r_state <= DONE;
                o_done  <= 1'b1;
              end else begin
                r_state <= ERR;
                o_err   <= 1'b1;
              end
`else
              o_we    <= 1'b1;
              o_waddr <= r_addr;
              o_wdata <= i_data;
              o_len   <= o_len + LEN_W'(1);
              r_state <= DONE;
              o_done  <= 1'b1;
`endif
            end else begin
              o_we    <= 1'b1;
              o_waddr <= r_addr;
              o_wdata <= i_data;
              o_len   <= o_len + LEN_W'(1);
              // last location filled without i_last: program too large
              if (r_addr == LAST_ADDR) begin
                r_state <= ERR;
                o_err   <= 1'b1;
                o_ready <= 1'b0;
              end else begin
                r_addr <= r_addr + ADDR_W'(1);
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          o_inCmd <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader; checksum cases run when PROG_LOADER_CHKSUM_EN is defined.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst, i_start, i_valid, i_last;
  logic [7:0] i_data;
  logic       o_ready, o_inCmd, o_we, o_done, o_err;
  logic [7:0] o_waddr, o_wdata;
  logic [8:0] o_len;

  typedef struct {
    int         cyc;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic [7:0] d3 [3] = '{8'h11, 8'h22, 8'h33};

  prog_loader dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_inCmd (o_inCmd),
    .o_we    (o_we),
    .o_waddr (o_waddr),
    .o_wdata (o_wdata),
    .o_len   (o_len),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write or done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (o_we || o_done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: cyc=%0d we=%0b done=%0b addr=%0d data=%h, nothing expected",
                 cyc, o_we, o_done, o_waddr, o_wdata);
      end else begin
        e = sb.pop_front();
        if (o_we !== e.we || o_done !== e.done || cyc != e.cyc ||
            (e.we && (o_waddr !== e.addr || o_wdata !== e.data))) begin
          n_err++;
          $display("FAIL write: got cyc=%0d we=%0b done=%0b addr=%0d data=%h, expected cyc=%0d we=%0b done=%0b addr=%0d data=%h",
                   cyc, o_we, o_done, o_waddr, o_wdata, e.cyc, e.we, e.done, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic [7:0] addr);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    step();
    sb.push_back('{cyc, 1'b1, addr, d, last});
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 0);
    check({tag, "_inCmd"}, 32'(o_inCmd), 0);
    check({tag, "_we"},    32'(o_we),    0);
    check({tag, "_waddr"}, 32'(o_waddr), 0);
    check({tag, "_wdata"}, 32'(o_wdata), 0);
    check({tag, "_len"},   32'(o_len),   0);
    check({tag, "_done"},  32'(o_done),  0);
    check({tag, "_err"},   32'(o_err),   0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_data = '0;
    step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check("idle_inCmd", 32'(o_inCmd), 0);

`ifndef PROG_LOADER_CHKSUM_EN
    // basic back-to-back load
    pulse_start();
    check("load_inCmd", 32'(o_inCmd), 1);
    check("load_ready", 32'(o_ready), 1);
    send(8'h11, 1'b0, 8'd0);
    send(8'h22, 1'b0, 8'd1);
    send(8'h33, 1'b1, 8'd2);
    check("done_inCmd", 32'(o_inCmd), 1);
    check("done_ready", 32'(o_ready), 0);
    check("basic_len", 32'(o_len), 3);
    step();
    check("after_done_inCmd", 32'(o_inCmd), 0);

    // gapped stream, then i_start during DONE is ignored
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send(d3[i], i == 2, 8'(i));
      if (i < 2) begin
        step(); step();
      end
    end
    check("gap_len", 32'(o_len), 3);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("done_start_inCmd", 32'(o_inCmd), 0);
    check("done_start_ready", 32'(o_ready), 0);

    // restart mid-load discards the same-cycle byte
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), 1'b0, 8'(i));
    i_start = 1'b1; i_valid = 1'b1; i_data = 8'hAA;
    step();
    i_start = 1'b0; i_valid = 1'b0;
    check("restart_len", 32'(o_len), 0);
    check("restart_ready", 32'(o_ready), 1);
    send(8'hBB, 1'b1, 8'd0);
    check("restart_final_len", 32'(o_len), 1);
    step();
`else
    // checksum matches: the checksum byte is not written
    pulse_start();
    send(8'h01, 1'b0, 8'd0);
    send(8'h02, 1'b0, 8'd1);
    i_valid = 1'b1; i_data = 8'h03; i_last = 1'b1;
    step();
    sb.push_back('{cyc, 1'b0, 8'd0, 8'd0, 1'b1});
    i_valid = 1'b0; i_last = 1'b0;
    check("chk_ok_len", 32'(o_len), 2);
    check("chk_ok_err", 32'(o_err), 0);
    step();
    check("chk_ok_inCmd", 32'(o_inCmd), 0);

    // checksum mismatch: error, no done, PC still held
    pulse_start();
    send(8'h01, 1'b0, 8'd0);
    send(8'h02, 1'b0, 8'd1);
    i_valid = 1'b1; i_data = 8'h04; i_last = 1'b1;
    step();
    i_valid = 1'b0; i_last = 1'b0;
    check("chk_bad_err", 32'(o_err), 1);
    check("chk_bad_ready", 32'(o_ready), 0);
    step();
    check("chk_bad_inCmd", 32'(o_inCmd), 1);
    check("chk_bad_err_sticky", 32'(o_err), 1);
`endif

    // overflow: 256 bytes fill memory, 257th refused
    pulse_start();
    for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A, 1'b0, 8'(i));
    check("ovf_err", 32'(o_err), 1);
    check("ovf_ready", 32'(o_ready), 0);
    check("ovf_len", 32'(o_len), 256);
    check("ovf_inCmd", 32'(o_inCmd), 1);
    i_valid = 1'b1; i_data = 8'hFF;
    step();
    i_valid = 1'b0;
    check("ovf257_len", 32'(o_len), 256);
    check("ovf257_inCmd", 32'(o_inCmd), 1);

    // start out of ERR clears the flag and reloads from 0
    pulse_start();
    check("reload_err", 32'(o_err), 0);
    check("reload_ready", 32'(o_ready), 1);
    check("reload_len", 32'(o_len), 0);
    send(8'hC0, 1'b0, 8'd0);
    send(8'hC1, 1'b0, 8'd1);
    send(8'hC2, 1'b0, 8'd2);

    // reset alongside a valid byte: no write, everything cleared
    rst = 1'b1; i_valid = 1'b1; i_data = 8'hC3;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    step();
    i_valid = 1'b0;
    check("post_rst_ready", 32'(o_ready), 0);
    step(); step();

    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
